// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for the port-B arbiter: per-channel request fields,
// one-hot grant and one-hot read response with a shared read-data bus.
interface mem_port_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_we;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_wdata;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH-1:0]        rsp_valid;
   logic [DATA_W-1:0]        rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port B; one issue per cycle, combinational grant.
// Read response one-hot to the issuer RAM_LAT+1 cycles after the registered issue; arb_en=0 stalls grants only.
module mem_port_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arb_en,
   mem_port_arbiter_if.slave bus,
   output logic              wren_b,
   output logic [ADDR_W-1:0] address_b,
   output logic [DATA_W-1:0] data_b,
   input  logic [DATA_W-1:0] q_b
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TAG_N = RAM_LAT + 1;

   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   rr_next;
   logic [CH_W-1:0]   gnt_id;
   logic [CH_W-1:0]   idx;
   logic              found;
   logic              accept;
   logic [NUM_CH-1:0] grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic              iss_vld;
   logic [CH_W-1:0]   iss_ch;
   logic [TAG_N-1:0]  tag_vld;
   logic [CH_W-1:0]   tag_ch [TAG_N];
   logic [NUM_CH-1:0] rsp_onehot;

   // Search starts at rr_ptr and wraps; grant is forced low while in reset.
   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      idx    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
         if (!found && bus.req_valid[idx]) begin
            found  = 1'b1;
            gnt_id = idx;
         end
      end
      accept = found & arb_en & reset;
      grant  = '0;
      if (accept) begin
         grant[gnt_id] = 1'b1;
      end
      rr_next = (gnt_id == CH_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (gnt_id == CH_W'(c)) begin
            sel_we    = bus.req_we[c];
            sel_addr  = bus.req_addr[c*ADDR_W +: ADDR_W];
            sel_wdata = bus.req_wdata[c*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.req_ready = grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         wren_b    <= 1'b0;
         address_b <= '0;
         data_b    <= '0;
         iss_vld   <= 1'b0;
         iss_ch    <= '0;
      end else begin
         wren_b  <= 1'b0;
         iss_vld <= 1'b0;
         if (accept) begin
            rr_ptr    <= rr_next;
            wren_b    <= sel_we;
            address_b <= sel_addr;
            data_b    <= sel_wdata;
            iss_vld   <= ~sel_we;
            iss_ch    <= gnt_id;
         end
      end
   end

   // Tag pipe tracks the RAM's own latency after the issue register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_vld <= '0;
         for (int s = 0; s < TAG_N; s++) begin
            tag_ch[s] <= '0;
         end
      end else begin
         tag_vld   <= {tag_vld[TAG_N-2:0], iss_vld};
         tag_ch[0] <= iss_ch;
         for (int s = 1; s < TAG_N; s++) begin
            tag_ch[s] <= tag_ch[s-1];
         end
      end
   end

   always_comb begin
      rsp_onehot = '0;
      if (tag_vld[TAG_N-1]) begin
         rsp_onehot[tag_ch[TAG_N-1]] = 1'b1;
      end
   end

   assign bus.rsp_valid = rsp_onehot;
   assign bus.rsp_rdata = tag_vld[TAG_N-1] ? q_b : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: RAM_LAT=1 instance with a behavioural RAM, plus a RAM_LAT=3 instance for mid-flight reset.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, reset3, arb_en, arb_en3, ram_load;
   logic        wren_b, wren_b3;
   logic [15:0] address_b, data_b, q_b, address_b3, data_b3, q_b3;
   int          checks = 0;
   int          passes = 0;

   mem_port_arbiter_if #(.NUM_CH(4), .DATA_W(16), .ADDR_W(16)) bus ();
   mem_port_arbiter_if #(.NUM_CH(4), .DATA_W(16), .ADDR_W(16)) bus3 ();

   mem_port_arbiter #(.NUM_CH(4), .DATA_W(16), .ADDR_W(16), .RAM_LAT(1)) dut (
      .clk(clk), .reset(reset), .arb_en(arb_en), .bus(bus),
      .wren_b(wren_b), .address_b(address_b), .data_b(data_b), .q_b(q_b)
   );

   mem_port_arbiter #(.NUM_CH(4), .DATA_W(16), .ADDR_W(16), .RAM_LAT(3)) dut3 (
      .clk(clk), .reset(reset3), .arb_en(arb_en3), .bus(bus3),
      .wren_b(wren_b3), .address_b(address_b3), .data_b(data_b3), .q_b(q_b3)
   );

   assign q_b3 = 16'h5A5A;

   // Synchronous RAM: address sampled at the edge after issue, data one cycle later.
   logic [15:0] mem [0:255];
   logic [15:0] rd0, rd1;
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
         mem[8'h10] <= 16'hBEEF;
      end else begin
         if (wren_b) mem[address_b[7:0]] <= data_b;
         rd0 <= mem[address_b[7:0]];
         rd1 <= rd0;
      end
   end
   assign q_b = rd1;

   task automatic clear_req();
      bus.req_valid = '0;
      bus.req_we    = '0;
   endtask

   task automatic set_rd(input int c, input logic [15:0] a);
      bus.req_valid[c] = 1'b1;
      bus.req_we[c]    = 1'b0;
      bus.req_addr[c*16 +: 16] = a;
   endtask

   task automatic set_wr(input int c, input logic [15:0] a, input logic [15:0] d);
      bus.req_valid[c] = 1'b1;
      bus.req_we[c]    = 1'b1;
      bus.req_addr[c*16 +: 16]  = a;
      bus.req_wdata[c*16 +: 16] = d;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.req_valid = 4'hF;
      bus.req_we    = 4'h0;
      bus3.req_valid = 4'hF;
      repeat (3) begin
         @(negedge clk);
         checks++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); else passes++;
         checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid); else passes++;
         checks++; if (wren_b !== 1'b0) $display("FAIL rst_wren_b got=%b exp=0", wren_b); else passes++;
      end
      checks++; if (address_b !== 16'h0) $display("FAIL rst_address_b got=%h exp=0000", address_b); else passes++;
      checks++; if (data_b !== 16'h0) $display("FAIL rst_data_b got=%h exp=0000", data_b); else passes++;
      checks++; if (bus3.req_ready !== 4'b0000) $display("FAIL rst3_ready got=%b exp=0000", bus3.req_ready); else passes++;
      ram_load = 1'b0;
      bus3.req_valid = '0;
      reset  = 1'b1;
      reset3 = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_first_grant got=%b exp=0001", bus.req_ready); else passes++;
      @(negedge clk);
      clear_req();
      idle(4);
   endtask

   task automatic test_single_read();
      set_rd(2, 16'h0010);
      #1;
      checks++; if (bus.req_ready !== 4'b0100) $display("FAIL rd_grant got=%b exp=0100", bus.req_ready); else passes++;
      @(negedge clk);
      clear_req();
      checks++; if (address_b !== 16'h0010) $display("FAIL rd_address_b got=%h exp=0010", address_b); else passes++;
      checks++; if (wren_b !== 1'b0) $display("FAIL rd_wren_b got=%b exp=0", wren_b); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL rd_rsp_early got=%b exp=0000", bus.rsp_valid); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0100) $display("FAIL rd_rsp_valid got=%b exp=0100", bus.rsp_valid); else passes++;
      checks++; if (bus.rsp_rdata !== 16'hBEEF) $display("FAIL rd_rsp_rdata got=%h exp=BEEF", bus.rsp_rdata); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL rd_rsp_once got=%b exp=0000", bus.rsp_valid); else passes++;
      checks++; if (bus.rsp_rdata !== 16'h0) $display("FAIL rd_rdata_idle got=%h exp=0000", bus.rsp_rdata); else passes++;
      idle(2);
   endtask

   task automatic test_rr_wrap();
      logic [3:0] exp;
      set_rd(1, 16'h0041);
      #1;
      checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rr_setup got=%b exp=0010", bus.req_ready); else passes++;
      @(negedge clk);
      clear_req();
      for (int c = 0; c < 4; c++) set_rd(c, 16'h0040 + 16'(c));
      for (int i = 0; i < 8; i++) begin
         #1;
         exp = 4'(1 << ((2 + i) % 4));
         checks++; if (bus.req_ready !== exp) $display("FAIL rr_order[%0d] got=%b exp=%b", i, bus.req_ready, exp); else passes++;
         @(negedge clk);
      end
      clear_req();
      idle(4);
   endtask

   task automatic test_write_read();
      set_wr(1, 16'h0005, 16'h1234);
      #1;
      checks++; if (bus.req_ready !== 4'b0010) $display("FAIL wr_grant got=%b exp=0010", bus.req_ready); else passes++;
      @(negedge clk);
      checks++; if (wren_b !== 1'b1) $display("FAIL wr_wren_b got=%b exp=1", wren_b); else passes++;
      checks++; if (address_b !== 16'h0005) $display("FAIL wr_address_b got=%h exp=0005", address_b); else passes++;
      checks++; if (data_b !== 16'h1234) $display("FAIL wr_data_b got=%h exp=1234", data_b); else passes++;
      clear_req();
      set_rd(3, 16'h0005);
      #1;
      checks++; if (bus.req_ready !== 4'b1000) $display("FAIL wrrd_grant got=%b exp=1000", bus.req_ready); else passes++;
      @(negedge clk);
      clear_req();
      checks++; if (wren_b !== 1'b0) $display("FAIL wrrd_wren_b got=%b exp=0", wren_b); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL wrrd_rsp_early got=%b exp=0000", bus.rsp_valid); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b1000) $display("FAIL wrrd_rsp_valid got=%b exp=1000", bus.rsp_valid); else passes++;
      checks++; if (bus.rsp_rdata !== 16'h1234) $display("FAIL wrrd_rsp_rdata got=%h exp=1234", bus.rsp_rdata); else passes++;
      idle(2);
   endtask

   task automatic test_arb_en_drop();
      set_rd(0, 16'h0020);
      set_rd(1, 16'h0021);
      set_rd(2, 16'h0022);
      #1;
      checks++; if (bus.req_ready !== 4'b0001) $display("FAIL en_grant0 got=%b exp=0001", bus.req_ready); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.req_ready !== 4'b0010) $display("FAIL en_grant1 got=%b exp=0010", bus.req_ready); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.req_ready !== 4'b0100) $display("FAIL en_grant2 got=%b exp=0100", bus.req_ready); else passes++;
      @(negedge clk);
      arb_en = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 4'b0000) $display("FAIL en_off_ready got=%b exp=0000", bus.req_ready); else passes++;
      checks++; if (bus.rsp_valid !== 4'b0001) $display("FAIL en_rsp0 got=%b exp=0001", bus.rsp_valid); else passes++;
      checks++; if (bus.rsp_rdata !== 16'hA020) $display("FAIL en_rdata0 got=%h exp=A020", bus.rsp_rdata); else passes++;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000) $display("FAIL en_off_ready2 got=%b exp=0000", bus.req_ready); else passes++;
      checks++; if (bus.rsp_valid !== 4'b0010) $display("FAIL en_rsp1 got=%b exp=0010", bus.rsp_valid); else passes++;
      checks++; if (bus.rsp_rdata !== 16'hA021) $display("FAIL en_rdata1 got=%h exp=A021", bus.rsp_rdata); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0100) $display("FAIL en_rsp2 got=%b exp=0100", bus.rsp_valid); else passes++;
      checks++; if (bus.rsp_rdata !== 16'hA022) $display("FAIL en_rdata2 got=%h exp=A022", bus.rsp_rdata); else passes++;
      checks++; if (address_b !== 16'h0022) $display("FAIL en_addr_hold got=%h exp=0022", address_b); else passes++;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL en_rsp_done got=%b exp=0000", bus.rsp_valid); else passes++;
      set_rd(3, 16'h0023);
      arb_en = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b1000) $display("FAIL en_resume got=%b exp=1000", bus.req_ready); else passes++;
      clear_req();
      idle(2);
   endtask

   task automatic test_reset_midflight();
      bus3.req_valid = 4'b0010;
      bus3.req_addr  = 64'h0000_0000_0031_0000;
      #1;
      checks++; if (bus3.req_ready !== 4'b0010) $display("FAIL mf_grant1 got=%b exp=0010", bus3.req_ready); else passes++;
      @(negedge clk);
      bus3.req_valid = 4'b0100;
      bus3.req_addr  = 64'h0000_0032_0000_0000;
      #1;
      checks++; if (bus3.req_ready !== 4'b0100) $display("FAIL mf_grant2 got=%b exp=0100", bus3.req_ready); else passes++;
      @(negedge clk);
      bus3.req_valid = '0;
      @(negedge clk);
      reset3 = 1'b0;
      #1;
      checks++; if (bus3.rsp_valid !== 4'b0000) $display("FAIL mf_in_reset got=%b exp=0000", bus3.rsp_valid); else passes++;
      idle(2);
      reset3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (bus3.rsp_valid !== 4'b0000) $display("FAIL mf_no_rsp[%0d] got=%b exp=0000", i, bus3.rsp_valid); else passes++;
         @(negedge clk);
      end
      bus3.req_valid = 4'hF;
      #1;
      checks++; if (bus3.req_ready !== 4'b0001) $display("FAIL mf_rr_reset got=%b exp=0001", bus3.req_ready); else passes++;
      bus3.req_valid = '0;
   endtask

   initial begin
      reset    = 1'b0;
      reset3   = 1'b0;
      arb_en   = 1'b1;
      arb_en3  = 1'b1;
      ram_load = 1'b1;
      bus.req_valid  = '0;
      bus.req_we     = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus3.req_valid = '0;
      bus3.req_we    = '0;
      bus3.req_addr  = '0;
      bus3.req_wdata = '0;
      test_reset();
      test_single_read();
      test_rr_wrap();
      test_write_read();
      test_arb_en_drop();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
